vga_frame_writer: RTL and testbench

- Fills the 1-bpp frame memory that the VGA display controllers scan out.
- Takes a raster-order pixel stream over a valid/ready handshake and packs 8 pixels per byte, LSB first: pixel x lands in bit x%8 of address y*(H_PIX/8)+x/8.
- Also provides a bulk clear command.
- Drives the write port of the frame RAM; the display side reads the other port.

---
 rtl/vga_frame_writer_if.sv | 38 +++
 rtl/vga_frame_writer.sv | 208 ++++++++++++++++++++
 tb/tb_vga_frame_writer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_writer_if.sv
// rtl/vga_frame_writer_if.sv - pixel stream and frame RAM write port bundle
//
// Purpose: groups the pixel-beat handshake into the frame writer and the
// write port it drives on the frame RAM.
//
// Signals:
//   s_valid   pixel beat valid (source -> writer)
//   s_ready   writer can accept a beat (writer -> source)
//   s_pixel   pixel value
//   s_sof     beat is pixel (0,0) of a new frame
//   ram_we    RAM write enable (writer -> RAM)
//   ram_addr  RAM write address, ADDR_W bits
//   ram_wdata RAM write data, 8 packed pixels
//
// Modports:
//   master  pixel source / RAM side of the system
//   slave   the frame writer
interface vga_frame_writer_if #(
   parameter int ADDR_W = 11
);
   logic              s_valid;
   logic              s_ready;
   logic              s_pixel;
   logic              s_sof;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;

   modport master (
      output s_valid, s_pixel, s_sof,
      input  s_ready, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  s_valid, s_pixel, s_sof,
      output s_ready, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - packs a raster pixel stream into 1-bpp frame RAM
//
// Purpose: accepts raster-order pixels over a valid/ready handshake, packs
// 8 pixels per byte (pixel x in bit x%8 of address y*(H_PIX/8)+x/8) and
// writes them to the frame RAM write port. A bulk clear fills the whole
// frame with a single pixel value, one byte per cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   clear_req   one-cycle request to fill the frame with clear_val
//   clear_val   fill pixel value, sampled when clear_req is taken
//   bus         pixel stream in / RAM write port out (slave modport)
//   busy        high while clearing or receiving a frame
//   frame_done  pulse coincident with the last write of a complete frame
//   sof_err     pulse the cycle after a start-of-frame arrives mid-frame
module vga_frame_writer #(
   parameter int H_PIX  = 128,
   parameter int V_PIX  = 128,
   parameter int ADDR_W = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_req,
   input  logic                  clear_val,
   vga_frame_writer_if.slave     bus,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  sof_err
);

   localparam int BYTES_PER_LINE = H_PIX / 8;
   localparam int FRAME_BYTES    = BYTES_PER_LINE * V_PIX;
   localparam int XW             = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW             = (V_PIX > 1) ? $clog2(V_PIX) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RECV  = 2'd2
   } state_t;

   state_t            state_q, state_d;

   // x_q/y_q hold the coordinate the next accepted pixel will occupy.
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [7:0]        shift_q, shift_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_val_q, clr_val_d;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              ready;
   logic              accept;
   logic [7:0]        byte_v;
   logic              last_x;
   logic              last_y;
   logic              byte_full;
   logic [ADDR_W-1:0] pix_addr;

   // Ready is gated by rst so the handshake is closed while reset is held,
   // and dropped in IDLE when a clear is requested so a simultaneous
   // start-of-frame beat is not swallowed by the clear.
   assign ready  = !rst && ((state_q == RECV) ||
                            ((state_q == IDLE) && !clear_req));
   assign accept = bus.s_valid && ready;

   assign last_x    = (x_q == XW'(H_PIX - 1));
   assign last_y    = (y_q == YW'(V_PIX - 1));
   assign byte_full = (x_q[2:0] == 3'd7);
   assign pix_addr  = ADDR_W'(y_q) * ADDR_W'(BYTES_PER_LINE)
                    + ADDR_W'(x_q >> 3);

   always_comb begin
      byte_v = shift_q;
      byte_v[x_q[2:0]] = bus.s_pixel;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      clr_val_d = clr_val_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               clr_val_d = clear_val;
               cnt_d     = '0;
               state_d   = CLEAR;
            end else if (accept && bus.s_sof) begin
               // Pixel (0,0): start a fresh byte and point at x = 1.
               shift_d = {7'd0, bus.s_pixel};
               x_d     = XW'(1);
               y_d     = '0;
               state_d = RECV;
            end
         end

         CLEAR: begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = {8{clr_val_q}};
            if (cnt_q == ADDR_W'(FRAME_BYTES - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end

         RECV: begin
            if (accept) begin
               if (bus.s_sof) begin
                  // Restart: the partially packed byte is dropped and this
                  // beat becomes pixel (0,0). A write registered on the
                  // previous edge is already on the port and still lands.
                  err_d   = 1'b1;
                  shift_d = {7'd0, bus.s_pixel};
                  x_d     = XW'(1);
                  y_d     = '0;
               end else begin
                  shift_d = byte_v;
                  if (byte_full) begin
                     we_d    = 1'b1;
                     addr_d  = pix_addr;
                     wdata_d = byte_v;
                  end
                  if (last_x) begin
                     x_d = '0;
                     if (last_y) begin
                        done_d  = 1'b1;
                        y_d     = '0;
                        state_d = IDLE;
                     end else begin
                        y_d = y_q + YW'(1);
                     end
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         shift_q   <= '0;
         cnt_q     <= '0;
         clr_val_q <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         clr_val_q <= clr_val_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.s_ready   = ready;
   assign bus.ram_we    = we_q;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;
   assign busy          = (state_q != IDLE);
   assign frame_done    = done_q;
   assign sof_err       = err_q;

endmodule

// File: tb/tb_vga_frame_writer.sv
// tb/tb_vga_frame_writer.sv - randomized self-checking bench for vga_frame_writer
module tb_vga_frame_writer;

   localparam int H_PIX       = 128;
   localparam int V_PIX       = 128;
   localparam int ADDR_W      = 11;
   localparam int BPL         = H_PIX / 8;
   localparam int FRAME_BYTES = BPL * V_PIX;
   localparam int NPIX        = H_PIX * V_PIX;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic clear_req = 1'b0;
   logic clear_val = 1'b0;
   logic busy;
   logic frame_done;
   logic sof_err;

   vga_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

   vga_frame_writer #(
      .H_PIX (H_PIX),
      .V_PIX (V_PIX),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .clear_val (clear_val),
      .bus       (bus),
      .busy      (busy),
      .frame_done(frame_done),
      .sof_err   (sof_err)
   );

   initial forever #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_CLEAR, M_RECV} mmode_t;
   mmode_t     mode     = M_IDLE;
   int         idx      = 0;
   int         clr_addr = 0;
   logic       clr_v    = 1'b0;
   logic [7:0] acc      = 8'd0;
   logic       e_we     = 1'b0;
   int         e_addr   = 0;
   logic [7:0] e_data   = 8'd0;
   logic       e_done   = 1'b0;
   logic       e_err    = 1'b0;

   logic [7:0] mem_obs [FRAME_BYTES];
   int wr_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, wr33 = 0;
   int last_done_addr = -1;

   task automatic place(input logic p);
      int x, y;
      x = idx % H_PIX;
      y = idx / H_PIX;
      acc[x % 8] = p;
      if (x % 8 == 7) begin
         e_we   = 1'b1;
         e_addr = y * BPL + x / 8;
         e_data = acc;
         if (idx == NPIX - 1) begin
            e_done = 1'b1;
            mode   = M_IDLE;
         end
      end
      idx++;
   endtask

   task automatic start_frame(input logic p);
      idx  = 0;
      acc  = 8'd0;
      mode = M_RECV;
      place(p);
   endtask

   initial begin
      logic exp_ready;
      forever begin
         @(negedge clk);
         exp_ready = !rst && (mode == M_RECV || (mode == M_IDLE && !clear_req));
         if (rst) begin
            mode   = M_IDLE;
            e_we   = 1'b0;
            e_done = 1'b0;
            e_err  = 1'b0;
         end
         check("s_ready", 32'(bus.s_ready), 32'(exp_ready));
         check("busy", 32'(busy), 32'(mode != M_IDLE));
         check("ram_we", 32'(bus.ram_we), 32'(e_we));
         check("frame_done", 32'(frame_done), 32'(e_done));
         check("sof_err", 32'(sof_err), 32'(e_err));
         if (e_we) begin
            check("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
            check("ram_wdata", 32'(bus.ram_wdata), 32'(e_data));
         end
         if (bus.ram_we) begin
            mem_obs[bus.ram_addr] = bus.ram_wdata;
            wr_cnt++;
            if (bus.ram_addr == ADDR_W'(33)) wr33++;
         end
         if (frame_done) begin
            done_cnt++;
            last_done_addr = int'(bus.ram_addr);
         end
         if (sof_err) err_cnt++;
         if (busy) busy_cnt++;

         e_we   = 1'b0;
         e_done = 1'b0;
         e_err  = 1'b0;
         if (!rst) begin
            case (mode)
               M_IDLE: begin
                  if (clear_req) begin
                     mode     = M_CLEAR;
                     clr_v    = clear_val;
                     clr_addr = 0;
                  end else if (bus.s_valid && bus.s_sof) begin
                     start_frame(bus.s_pixel);
                  end
               end
               M_CLEAR: begin
                  e_we   = 1'b1;
                  e_addr = clr_addr;
                  e_data = {8{clr_v}};
                  clr_addr++;
                  if (clr_addr == FRAME_BYTES) mode = M_IDLE;
               end
               M_RECV: begin
                  if (bus.s_valid) begin
                     if (bus.s_sof) begin
                        e_err = 1'b1;
                        start_frame(bus.s_pixel);
                     end else begin
                        place(bus.s_pixel);
                     end
                  end
               end
               default: mode = M_IDLE;
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   logic noise_clr = 1'b0;

   task automatic drive(input logic v, input logic p, input logic s);
      bus.s_valid = v;
      bus.s_pixel = p;
      bus.s_sof   = s;
      if (noise_clr) clear_req = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic p, input logic s, input int gap_pct);
      while ($urandom_range(0, 99) < gap_pct)
         drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive(1'b1, p, s);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
   endtask

   function automatic int count_fill_bad(input logic [7:0] want);
      int bad = 0;
      for (int a = 0; a < FRAME_BYTES; a++)
         if (mem_obs[a] !== want) bad++;
      return bad;
   endfunction

   initial begin
      int b0, w0, d0, e0, bad, w33;
      logic [7:0] pb, pb2;
      logic p, cv;

      bus.s_valid = 1'b0;
      bus.s_pixel = 1'b0;
      bus.s_sof   = 1'b0;
      idle(2);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(bus.s_ready), 32'd0);
      rst = 1'b0;
      idle(2);

      // 1: clear to ones
      do_reset();
      for (int a = 0; a < FRAME_BYTES; a++) mem_obs[a] = 8'h00;
      b0 = busy_cnt; w0 = wr_cnt; d0 = done_cnt;
      clear_val = 1'b1;
      clear_req = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      clear_req = 1'b0;
      clear_val = 1'b0;
      idle(FRAME_BYTES + 10);
      check("clr_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME_BYTES));
      check("clr_writes", 32'(wr_cnt - w0), 32'(FRAME_BYTES));
      check("clr_no_done", 32'(done_cnt - d0), 32'd0);
      check("clr_fill_bad", 32'(count_fill_bad(8'hFF)), 32'd0);

      // 2: bit order
      do_reset();
      mem_obs[0] = 8'h5A;
      w0 = wr_cnt;
      begin
         logic [7:0] pat;
         pat = 8'b0000_0011;
         for (int i = 0; i < 8; i++) send(pat[i], i == 0, 0);
      end
      idle(4);
      check("bitord_writes", 32'(wr_cnt - w0), 32'd1);
      check("bitord_byte", 32'(mem_obs[0]), 32'h03);

      // 3: diagonal frame with gaps and ignored clear requests
      do_reset();
      for (int a = 0; a < FRAME_BYTES; a++) mem_obs[a] = 8'hA5;
      w0 = wr_cnt; d0 = done_cnt;
      for (int i = 0; i < NPIX; i++) begin
         if (i == 1) noise_clr = 1'b1;
         send((i % H_PIX) == (i / H_PIX), i == 0, 30);
      end
      noise_clr = 1'b0;
      clear_req = 1'b0;
      idle(4);
      bad = 0;
      for (int a = 0; a < FRAME_BYTES; a++) begin
         int yy, xb;
         logic [7:0] want;
         yy = a / BPL;
         xb = a % BPL;
         want = (xb == yy / 8) ? 8'(1 << (yy % 8)) : 8'h00;
         if (mem_obs[a] !== want) bad++;
      end
      check("diag_bad_bytes", 32'(bad), 32'd0);
      check("diag_writes", 32'(wr_cnt - w0), 32'(FRAME_BYTES));
      check("diag_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("diag_done_addr", 32'(last_done_addr), 32'(FRAME_BYTES - 1));
      check("diag_idle", 32'(busy), 32'd0);

      // 4: beats without sof in IDLE are dropped
      do_reset();
      w0 = wr_cnt; e0 = err_cnt;
      repeat (10) send(1'($urandom_range(0, 1)), 1'b0, 20);
      idle(3);
      check("nosof_writes", 32'(wr_cnt - w0), 32'd0);
      check("nosof_err", 32'(err_cnt - e0), 32'd0);
      mem_obs[0] = 8'h00;
      pb = 8'($urandom);
      w0 = wr_cnt;
      for (int i = 0; i < 8; i++) send(pb[i], i == 0, 20);
      idle(3);
      check("sof_start_writes", 32'(wr_cnt - w0), 32'd1);
      check("sof_start_byte", 32'(mem_obs[0]), 32'(pb));

      // 5: sof at x=13, y=2 restarts the frame
      w0 = wr_cnt; e0 = err_cnt; w33 = wr33;
      for (int i = 8; i < 2 * H_PIX + 13; i++) send(1'($urandom_range(0, 1)), 1'b0, 20);
      pb2 = 8'($urandom);
      for (int i = 0; i < 8; i++) send(pb2[i], 1'(i == 0), 20);
      idle(3);
      check("midsof_err", 32'(err_cnt - e0), 32'd1);
      check("midsof_no33", 32'(wr33 - w33), 32'd0);
      check("midsof_writes", 32'(wr_cnt - w0), 32'd33);
      check("midsof_byte", 32'(mem_obs[0]), 32'(pb2));

      // 6: clear wins over a same-cycle sof beat; reset mid-frame
      do_reset();
      cv = 1'($urandom_range(0, 1));
      e0 = err_cnt;
      clear_val = cv;
      clear_req = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      clear_req = 1'b0;
      clear_val = ~cv;
      idle(FRAME_BYTES + 5);
      check("clrsof_fill_bad", 32'(count_fill_bad({8{cv}})), 32'd0);
      check("clrsof_err", 32'(err_cnt - e0), 32'd0);
      for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), i == 0, 0);
      check("pre_rst_we", 32'(bus.ram_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_we", 32'(bus.ram_we), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_ready", 32'(bus.s_ready), 32'd0);
      repeat (3) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      rst = 1'b0;
      w0 = wr_cnt;
      repeat (20) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      idle(3);
      check("post_rst_writes", 32'(wr_cnt - w0), 32'd0);
      pb = 8'($urandom);
      for (int i = 0; i < 8; i++) send(pb[i], i == 0, 10);
      idle(3);
      check("post_rst_byte", 32'(mem_obs[0]), 32'(pb));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
